text_screen_sequencer: RTL and testbench
========================================

Name: text_screen_sequencer

Overview:
- Frame-rate FSM that schedules the on-screen text overlays: title/idle, per-level "LEVEL n" banner, gameplay, timed GAME OVER screen.
- Drives the textbox overlay stage with the level number, overlay enables and blink phase.
- Gates gameplay while banners are shown.
- Sits between game logic (death counters, level-clear, start button) and the textbox rendering pipeline, in the pclk domain.

Parameters:
- BANNER_FRAMES, 120: frames the LEVEL banner stays up (min 1).
- GAMEOVER_FRAMES, 300: frames GAME OVER stays up before returning to idle (min 1).
- BLINK_FRAMES, 30: frames per blink half-period on GAME OVER (min 1).
- LIVES, 3: deaths per player that eliminate that player (1..15).
- MAX_LEVEL, 9: highest level; clearing it wraps to level 1.

Ports:
- pclk  in  1  pixel clock, sole clock.
- rst  in  1  asynchronous active-low reset.
- vsync_in  in  1  VGA vsync, active-high; rising edge = frame tick.
- start_btn  in  1  synchronous, debounced start request (level-sensitive, single-cycle sample).
- level_clear  in  1  one-cycle pulse from game logic: all enemies destroyed.
- dead_count_1  in  4  player-1 death count.
- dead_count_2  in  4  player-2 death count.
- pause_btn  in  1  debounced pause toggle; used only with PAUSE_EN.
- level_out  out  4  level number to the textbox/level ROM.
- banner_en  out  1  show the LEVEL banner.
- game_over_en  out  1  show the GAME OVER text.
- text_blink  out  1  blink phase; the textbox masks GAME OVER glyphs when 0.
- game_run  out  1  gameplay enable (enemies/players advance).
- paused  out  1  pause overlay enable; 0 without PAUSE_EN.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; level_out=0; banner_en=0; game_over_en=0; text_blink=0; game_run=0; paused=0.
  - Frame and blink counters=0; vsync edge register=0.
- Frame tick:
  - vsync_in is registered once; tick = vsync_q & ~vsync_q2.
  - tick is one cycle wide, 2 cycles after the vsync_in rise.
- Output timing:
  - All outputs are registered and are a function of the state.
  - Outputs update the cycle after a state transition (1-cycle latency).
- Frame counter:
  - Width $clog2(max(BANNER_FRAMES, GAMEOVER_FRAMES)).
  - Cleared on every state entry; increments on tick.
- IDLE:
  - start_btn=1 -> BANNER, level_out<=1.
  - All other inputs are ignored.
- BANNER:
  - banner_en=1, game_run=0.
  - On the tick with counter==BANNER_FRAMES-1 -> PLAY.
- PLAY:
  - game_run=1.
  - Elimination condition: dead_count_1>=LIVES AND dead_count_2>=LIVES -> GAME_OVER.
  - Else level_clear -> BANNER, level_out<=(level_out==MAX_LEVEL)?1:level_out+1.
  - Elimination and level_clear in the same cycle: GAME_OVER wins and the level is unchanged.
- GAME_OVER:
  - game_over_en=1, game_run=0, level_out held.
  - Blink counter counts ticks and wraps at BLINK_FRAMES-1; text_blink toggles on each wrap.
  - text_blink=1 on entry.
  - On the tick with frame counter==GAMEOVER_FRAMES-1 -> IDLE, level_out<=0.
  - start_btn is ignored in this state.
- text_blink=1 in all other states.
- level_clear outside PLAY is dropped; it is not queued.
- Death counters are sampled every cycle. No latching: a counter reset by game logic cancels the condition.
- A tick coinciding with a transition does not count toward the new state; the counter starts at 0.

Optional Feature:
- Macro TEXT_SEQ_PAUSE_EN.
- Defined:
  - Adds state PAUSE. A rising edge of pause_btn (edge-detected internally) in PLAY -> PAUSE with game_run=0 and paused=1.
  - A pause_btn rising edge in PAUSE -> PLAY.
  - The elimination condition is still checked in PAUSE -> GAME_OVER.
  - level_clear is dropped in PAUSE.
- Undefined: pause_btn is unused, paused is tied 0, and no PAUSE state exists.

Decomposition:
- Package text_seq_pkg:
  - State enum (IDLE, BANNER, PLAY, GAME_OVER, PAUSE).
  - Level width constant (4).
  - Default frame-count constants.
- One sub-module, frame_tick_gen: vsync two-flop edge detect that outputs a one-cycle tick. It is reused by other frame-paced blocks.

Test Plan:
1. Reset mid-BANNER (rst low for 3 cycles) -> all outputs 0 next cycle and state IDLE; start_btn then -> level_out=1, banner_en=1.
2. BANNER_FRAMES=4, start, 4 vsync pulses -> banner_en falls and game_run rises exactly one cycle after the transition on the 4th tick.
3. PLAY at level_out=9 (MAX_LEVEL=9), level_clear pulse -> banner_en=1, level_out=1.
4. PLAY, dead_count_1=3 and dead_count_2=3 asserted in the same cycle as level_clear -> game_over_en=1, level_out unchanged, game_run=0.
5. GAMEOVER_FRAMES=6, BLINK_FRAMES=2 -> text_blink sequence 1,1,0,0,1,1 across ticks; IDLE with level_out=0 after the 6th tick; start_btn held throughout is ignored until IDLE.
6. TEXT_SEQ_PAUSE_EN: pause_btn rise in PLAY -> paused=1, game_run=0; level_clear dropped; second rise -> PLAY with level unchanged; build without the macro -> paused stays 0.

Source files
------------

// File: rtl/text_screen_sequencer_pkg.sv
// text_screen_sequencer shared types and defaults.
// Optional pause support is enabled with TEXT_SEQ_PAUSE_EN.
package text_seq_pkg;

  localparam int LVL_W = 4;

  localparam int DEF_BANNER_FRAMES   = 120;
  localparam int DEF_GAMEOVER_FRAMES = 300;
  localparam int DEF_BLINK_FRAMES    = 30;
  localparam int DEF_LIVES           = 3;
  localparam int DEF_MAX_LEVEL       = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_BANNER,
    S_PLAY,
    S_GAME_OVER,
    S_PAUSE
  } state_e;

  function automatic int cnt_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/text_screen_sequencer_if.sv
// Game-logic / textbox bundle around the text screen sequencer.
// master = game side, slave = sequencer.
interface text_seq_if;
  import text_seq_pkg::*;

  logic             vsync_in;
  logic             start_btn;
  logic             level_clear;
  logic [3:0]       dead_count_1;
  logic [3:0]       dead_count_2;
  logic             pause_btn;
  logic [LVL_W-1:0] level_out;
  logic             banner_en;
  logic             game_over_en;
  logic             text_blink;
  logic             game_run;
  logic             paused;

  modport master (
    output vsync_in, start_btn, level_clear,
    output dead_count_1, dead_count_2, pause_btn,
    input  level_out, banner_en, game_over_en,
    input  text_blink, game_run, paused
  );

  modport slave (
    input  vsync_in, start_btn, level_clear,
    input  dead_count_1, dead_count_2, pause_btn,
    output level_out, banner_en, game_over_en,
    output text_blink, game_run, paused
  );

endinterface

// File: rtl/text_screen_sequencer_frame_tick_gen.sv
// Vsync rising-edge detector producing a one-cycle frame tick.
// Shared by frame-paced blocks in the pclk domain.
module frame_tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic vsync_in,
  output logic tick
);

  logic vsync_q, vsync_q2;

  // two-stage vsync history for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q  <= 1'b0;
      vsync_q2 <= 1'b0;
    end else begin
      vsync_q  <= vsync_in;
      vsync_q2 <= vsync_q;
    end
  end

  assign tick = vsync_q & ~vsync_q2;

endmodule

// File: rtl/text_screen_sequencer.sv
// Title / banner / play / game-over text overlay sequencer.
// Define TEXT_SEQ_PAUSE_EN to add the PAUSE state.
module text_screen_sequencer
  import text_seq_pkg::*;
#(
  parameter int BANNER_FRAMES   = DEF_BANNER_FRAMES,
  parameter int GAMEOVER_FRAMES = DEF_GAMEOVER_FRAMES,
  parameter int BLINK_FRAMES    = DEF_BLINK_FRAMES,
  parameter int LIVES           = DEF_LIVES,
  parameter int MAX_LEVEL       = DEF_MAX_LEVEL
) (
  input logic      pclk,
  input logic      rst,
  text_seq_if.slave bus
);

  localparam int MAXF =
    (BANNER_FRAMES > GAMEOVER_FRAMES) ?
    BANNER_FRAMES : GAMEOVER_FRAMES;
  localparam int CW = cnt_w(MAXF);
  localparam int BW = cnt_w(BLINK_FRAMES);

  localparam logic [CW-1:0] BAN_LAST =
    CW'(BANNER_FRAMES - 1);
  localparam logic [CW-1:0] GO_LAST =
    CW'(GAMEOVER_FRAMES - 1);
  localparam logic [BW-1:0] BLK_LAST =
    BW'(BLINK_FRAMES - 1);
  localparam logic [3:0] LIVES_L = 4'(LIVES);
  localparam logic [LVL_W-1:0] MAX_L =
    LVL_W'(MAX_LEVEL);
  localparam logic [LVL_W-1:0] LVL_ONE =
    LVL_W'(1);

  state_e           state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CW-1:0]    fcnt_q, fcnt_d;
  logic [BW-1:0]    bcnt_q, bcnt_d;
  logic             blink_q, blink_d;

  logic [LVL_W-1:0] level_out_q, level_out_d;
  logic             banner_q, banner_d;
  logic             gover_q, gover_d;
  logic             tblink_q, tblink_d;
  logic             run_q, run_d;
  logic             paused_q, paused_d;

  logic tick;
  logic elim;
  logic pause_rise;

  frame_tick_gen u_tick (
    .clk      (pclk),
    .rst_n    (rst),
    .vsync_in (bus.vsync_in),
    .tick     (tick)
  );

  assign elim = (bus.dead_count_1 >= LIVES_L) &&
                (bus.dead_count_2 >= LIVES_L);

`ifdef TEXT_SEQ_PAUSE_EN
  logic pause_q;

  // pause button history for rising-edge detection
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) pause_q <= 1'b0;
    else      pause_q <= bus.pause_btn;
  end

  assign pause_rise = bus.pause_btn & ~pause_q;
`else
  logic unused_pause;
  assign unused_pause = bus.pause_btn;
  assign pause_rise   = 1'b0;
`endif

  // next state, level and frame/blink counters
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    fcnt_d  = tick ? fcnt_q + 1'b1 : fcnt_q;
    bcnt_d  = bcnt_q;
    blink_d = blink_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.start_btn) begin
          state_d = S_BANNER;
          level_d = LVL_ONE;
        end
      end
      S_BANNER: begin
        if (tick && fcnt_q == BAN_LAST)
          state_d = S_PLAY;
      end
      S_PLAY: begin
        if (elim) begin
          state_d = S_GAME_OVER;
        end else if (pause_rise) begin
          state_d = S_PAUSE;
        end else if (bus.level_clear) begin
          state_d = S_BANNER;
          level_d = (level_q == MAX_L) ?
                    LVL_ONE : level_q + 1'b1;
        end
      end
      S_GAME_OVER: begin
        if (tick) begin
          if (bcnt_q == BLK_LAST) begin
            bcnt_d  = '0;
            blink_d = ~blink_q;
          end else begin
            bcnt_d = bcnt_q + 1'b1;
          end
          if (fcnt_q == GO_LAST) begin
            state_d = S_IDLE;
            level_d = '0;
          end
        end
      end
      S_PAUSE: begin
`ifdef TEXT_SEQ_PAUSE_EN
        if (elim)            state_d = S_GAME_OVER;
        else if (pause_rise) state_d = S_PLAY;
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
    // a tick on the entry edge is not counted
    if (state_d != state_q) begin
      fcnt_d  = '0;
      bcnt_d  = '0;
      blink_d = 1'b1;
    end
  end

  // outputs decoded from the current state, one cycle late
  always_comb begin
    level_out_d = level_q;
    banner_d    = (state_q == S_BANNER);
    gover_d     = (state_q == S_GAME_OVER);
    tblink_d    = (state_q == S_GAME_OVER) ?
                  blink_q : 1'b1;
    run_d       = (state_q == S_PLAY);
`ifdef TEXT_SEQ_PAUSE_EN
    paused_d    = (state_q == S_PAUSE);
`else
    paused_d    = 1'b0;
`endif
  end

  // sequencer state and registered outputs
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      level_q     <= '0;
      fcnt_q      <= '0;
      bcnt_q      <= '0;
      blink_q     <= 1'b0;
      level_out_q <= '0;
      banner_q    <= 1'b0;
      gover_q     <= 1'b0;
      tblink_q    <= 1'b0;
      run_q       <= 1'b0;
      paused_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      level_q     <= level_d;
      fcnt_q      <= fcnt_d;
      bcnt_q      <= bcnt_d;
      blink_q     <= blink_d;
      level_out_q <= level_out_d;
      banner_q    <= banner_d;
      gover_q     <= gover_d;
      tblink_q    <= tblink_d;
      run_q       <= run_d;
      paused_q    <= paused_d;
    end
  end

  assign bus.level_out    = level_out_q;
  assign bus.banner_en    = banner_q;
  assign bus.game_over_en = gover_q;
  assign bus.text_blink   = tblink_q;
  assign bus.game_run     = run_q;
  assign bus.paused       = paused_q;

endmodule

// File: tb/tb_text_screen_sequencer.sv
// Directed bench for text_screen_sequencer.
// Build with TEXT_SEQ_PAUSE_EN to cover the pause state.
module tb_text_screen_sequencer;

  logic pclk = 1'b0;
  logic rst  = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   exp_level = 0;

  text_seq_if bus ();

  text_screen_sequencer #(
    .BANNER_FRAMES   (4),
    .GAMEOVER_FRAMES (6),
    .BLINK_FRAMES    (2),
    .LIVES           (3),
    .MAX_LEVEL       (9)
  ) dut (
    .pclk (pclk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  always #5 pclk = ~pclk;

  task automatic cyc(input int n);
    repeat (n) @(negedge pclk);
  endtask

  // vsync high 2 cycles, low 2: tick acts at
  // the 2nd edge, outputs follow at the 3rd
  task automatic frame();
    bus.vsync_in = 1'b1;
    cyc(2);
    bus.vsync_in = 1'b0;
    cyc(2);
  endtask

  task automatic pulse_start();
    bus.start_btn = 1'b1;
    cyc(1);
    bus.start_btn = 1'b0;
    cyc(1);
  endtask

  task automatic pulse_clear();
    bus.level_clear = 1'b1;
    cyc(1);
    bus.level_clear = 1'b0;
    cyc(1);
  endtask

  function automatic logic [8:0] outs();
    return {bus.level_out, bus.banner_en,
            bus.game_over_en, bus.text_blink,
            bus.game_run, bus.paused};
  endfunction

  task automatic test_reset();
    bus.vsync_in     = 1'b0;
    bus.start_btn    = 1'b0;
    bus.level_clear  = 1'b0;
    bus.dead_count_1 = 4'd0;
    bus.dead_count_2 = 4'd0;
    bus.pause_btn    = 1'b0;
    rst = 1'b0;
    cyc(3);
    vec_cnt++;
    if (outs() !== 9'b0) begin
      err_cnt++;
      $display("FAIL por_outs got %b exp %b",
               outs(), 9'b0);
    end
    rst = 1'b1;
    cyc(1);
    vec_cnt++;
    if (outs() !== 9'b0000_0_0_1_0_0) begin
      err_cnt++;
      $display("FAIL idle_outs got %b exp %b",
               outs(), 9'b0000_0_0_1_0_0);
    end
    pulse_start();
    frame();
    rst = 1'b0;
    cyc(1);
    vec_cnt++;
    if (outs() !== 9'b0) begin
      err_cnt++;
      $display("FAIL midban_rst got %b exp %b",
               outs(), 9'b0);
    end
    cyc(2);
    rst = 1'b1;
    cyc(1);
    vec_cnt++;
    if (outs() !== 9'b0000_0_0_1_0_0) begin
      err_cnt++;
      $display("FAIL post_rst got %b exp %b",
               outs(), 9'b0000_0_0_1_0_0);
    end
    pulse_start();
    exp_level = 1;
    vec_cnt++;
    if (outs() !== 9'b0001_1_0_1_0_0) begin
      err_cnt++;
      $display("FAIL start got %b exp %b",
               outs(), 9'b0001_1_0_1_0_0);
    end
  endtask

  task automatic test_banner();
    repeat (3) frame();
    vec_cnt++;
    if (bus.banner_en !== 1'b1 ||
        bus.game_run !== 1'b0) begin
      err_cnt++;
      $display("FAIL ban3 got b%b r%b exp b1 r0",
               bus.banner_en, bus.game_run);
    end
    bus.vsync_in = 1'b1;
    cyc(2);
    vec_cnt++;
    if (bus.banner_en !== 1'b1 ||
        bus.game_run !== 1'b0) begin
      err_cnt++;
      $display("FAIL ban_edge got b%b r%b exp b1 r0",
               bus.banner_en, bus.game_run);
    end
    bus.vsync_in = 1'b0;
    cyc(1);
    vec_cnt++;
    if (bus.banner_en !== 1'b0 ||
        bus.game_run !== 1'b1) begin
      err_cnt++;
      $display("FAIL ban_play got b%b r%b exp b0 r1",
               bus.banner_en, bus.game_run);
    end
    cyc(1);
  endtask

  task automatic test_level_wrap();
    for (int i = 0; i < 9; i++) begin
      pulse_clear();
      exp_level = (exp_level == 9) ? 1 : exp_level + 1;
      vec_cnt++;
      if (bus.level_out !== 4'(exp_level) ||
          bus.banner_en !== 1'b1) begin
        err_cnt++;
        $display("FAIL lvl%0d got %0d b%b exp %0d b1",
                 i, bus.level_out, bus.banner_en,
                 exp_level);
      end
      if (i == 8) pulse_clear();
      repeat (4) frame();
    end
    vec_cnt++;
    if (bus.level_out !== 4'd1 ||
        bus.game_run !== 1'b1) begin
      err_cnt++;
      $display("FAIL clr_drop got %0d r%b exp 1 r1",
               bus.level_out, bus.game_run);
    end
  endtask

  task automatic test_pause();
`ifdef TEXT_SEQ_PAUSE_EN
    bus.pause_btn = 1'b1;
    cyc(2);
    vec_cnt++;
    if (bus.paused !== 1'b1 ||
        bus.game_run !== 1'b0) begin
      err_cnt++;
      $display("FAIL pause_on got p%b r%b exp p1 r0",
               bus.paused, bus.game_run);
    end
    pulse_clear();
    bus.pause_btn = 1'b0;
    cyc(2);
    vec_cnt++;
    if (bus.paused !== 1'b1 ||
        bus.banner_en !== 1'b0) begin
      err_cnt++;
      $display("FAIL pause_hold got p%b b%b exp p1 b0",
               bus.paused, bus.banner_en);
    end
    bus.pause_btn = 1'b1;
    cyc(2);
    vec_cnt++;
    if (bus.paused !== 1'b0 ||
        bus.game_run !== 1'b1 ||
        bus.level_out !== 4'(exp_level)) begin
      err_cnt++;
      $display("FAIL pause_off got p%b r%b l%0d exp p0 r1 l%0d",
               bus.paused, bus.game_run,
               bus.level_out, exp_level);
    end
    bus.pause_btn = 1'b0;
    cyc(1);
`else
    bus.pause_btn = 1'b1;
    cyc(3);
    vec_cnt++;
    if (bus.paused !== 1'b0 ||
        bus.game_run !== 1'b1) begin
      err_cnt++;
      $display("FAIL nopause got p%b r%b exp p0 r1",
               bus.paused, bus.game_run);
    end
    bus.pause_btn = 1'b0;
    cyc(1);
`endif
  endtask

  task automatic test_elim_vs_clear();
    bus.dead_count_1 = 4'd3;
    bus.dead_count_2 = 4'd2;
    cyc(3);
    vec_cnt++;
    if (bus.game_run !== 1'b1 ||
        bus.game_over_en !== 1'b0) begin
      err_cnt++;
      $display("FAIL one_dead got r%b g%b exp r1 g0",
               bus.game_run, bus.game_over_en);
    end
    bus.dead_count_2 = 4'd3;
    bus.level_clear  = 1'b1;
    cyc(1);
    bus.level_clear  = 1'b0;
    cyc(1);
    vec_cnt++;
    if (outs() !== {4'(exp_level), 5'b0_1_1_0_0}) begin
      err_cnt++;
      $display("FAIL elim_clr got %b exp %b",
               outs(), {4'(exp_level), 5'b0_1_1_0_0});
    end
    bus.dead_count_1 = 4'd0;
    bus.dead_count_2 = 4'd0;
  endtask

  task automatic test_game_over_blink();
    logic [5:0] seq;
    seq = 6'b110011;
    bus.start_btn = 1'b1;
    for (int k = 0; k < 6; k++) begin
      vec_cnt++;
      if (bus.text_blink !== seq[5-k] ||
          bus.game_over_en !== 1'b1 ||
          bus.banner_en !== 1'b0) begin
        err_cnt++;
        $display("FAIL blink%0d got t%b g%b b%b exp t%b g1 b0",
                 k, bus.text_blink, bus.game_over_en,
                 bus.banner_en, seq[5-k]);
      end
      if (k < 5) frame();
    end
    bus.vsync_in = 1'b1;
    cyc(2);
    bus.vsync_in = 1'b0;
    cyc(1);
    vec_cnt++;
    if (outs() !== 9'b0000_0_0_1_0_0) begin
      err_cnt++;
      $display("FAIL go_idle got %b exp %b",
               outs(), 9'b0000_0_0_1_0_0);
    end
    cyc(1);
    vec_cnt++;
    if (bus.banner_en !== 1'b1 ||
        bus.level_out !== 4'd1) begin
      err_cnt++;
      $display("FAIL restart got b%b l%0d exp b1 l1",
               bus.banner_en, bus.level_out);
    end
    bus.start_btn = 1'b0;
    cyc(2);
  endtask

  initial begin
    test_reset();
    test_banner();
    test_level_wrap();
    test_pause();
    test_elim_vs_clear();
    test_game_over_blink();
    $display("== %0d vectors applied, %0d miscompares ==",
             vec_cnt, err_cnt);
    $finish;
  end

endmodule
